i2c_byte_master: RTL and testbench

//  Downstream consumer of the divided bus-rate timing. Turns byte-level write commands into

---
 rtl/i2c_byte_master_if.sv | 28 ++
 rtl/i2c_byte_master.sv | 150 +++++++++++++++
 tb/tb_i2c_byte_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_byte_master_if.sv
// Command and bus-pin bundle for the I2C byte master.
// master = the byte master itself, slave = command source / bus model side.
interface i2c_byte_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_start;
  logic       cmd_stop;
  logic       done;
  logic       ack_n;
  logic       busy;
  logic       scl_o;
  logic       sda_o;
  logic       sda_i;
  logic [2:0] dbg_state;

  // Handshake: a command transfers on the clk_in posedge where cmd_valid and
  // cmd_ready are both high; cmd_valid while cmd_ready is low is ignored.
  modport master (
    input  cmd_valid, cmd_data, cmd_start, cmd_stop, sda_i,
    output cmd_ready, done, ack_n, busy, scl_o, sda_o, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_data, cmd_start, cmd_stop, sda_i,
    input  cmd_ready, done, ack_n, busy, scl_o, sda_o, dbg_state
  );
endinterface

// File: rtl/i2c_byte_master.sv
// Byte-level I2C write master: optional START, 8 data bits MSB first, ACK sample,
// optional STOP. Every SCL bit is four quarters of QDIV clk_in cycles.
module i2c_byte_master #(
  parameter int unsigned QDIV = 5
) (
  input  logic              clk_in,
  input  logic              rst,
  i2c_byte_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       stop_q, stop_d;
  logic       hold_q, hold_d;
  logic       ack_q, ack_d;
  logic       done_q, done_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic       tick;
  logic       ready;

  assign ready = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign tick  = (cnt_q == 8'(QDIV - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    data_d  = data_q;
    stop_d  = stop_q;
    hold_d  = hold_q;
    ack_d   = ack_q;
    done_d  = 1'b0;
    scl_d   = 1'b1;
    sda_d   = 1'b1;

    if (ready) begin
      if (bus.cmd_valid) begin
        data_d  = bus.cmd_data;
        stop_d  = bus.cmd_stop;
        hold_d  = (state_q == S_HOLD);
        cnt_d   = '0;
        qtr_d   = '0;
        bit_d   = '0;
        // From IDLE the bus is closed, so a START is always required.
        state_d = (bus.cmd_start || state_q == S_IDLE) ? S_START : S_BIT;
      end
    end else begin
      cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
      if (tick) qtr_d = qtr_q + 2'd1;
      if (tick && state_q == S_ACK && qtr_q == 2'd2) ack_d = bus.sda_i;
      if (tick && qtr_q == 2'd3) begin
        case (state_q)
          S_START: state_d = S_BIT;
          S_BIT: begin
            if (bit_q == 3'd7) state_d = S_ACK;
            else bit_d = bit_q + 3'd1;
          end
          S_ACK: begin
            state_d = stop_q ? S_STOP : S_HOLD;
            done_d  = !stop_q;
          end
          S_STOP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Pin levels decoded from the next state so they are registered with it.
    case (state_d)
      S_START: begin
        scl_d = (qtr_d == 2'd0) ? !hold_d : 1'b1;
        sda_d = !qtr_d[1];
      end
      S_BIT: begin
        scl_d = qtr_d[1];
        sda_d = data_d[3'd7 - bit_d];
      end
      S_ACK: begin
        scl_d = qtr_d[1];
        sda_d = 1'b1;
      end
      S_STOP: begin
        scl_d = (qtr_d != 2'd0);
        sda_d = qtr_d[1];
      end
      S_HOLD: begin
        scl_d = 1'b0;
        sda_d = 1'b1;
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      stop_q  <= 1'b0;
      hold_q  <= 1'b0;
      ack_q   <= 1'b1;
      done_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      stop_q  <= stop_d;
      hold_q  <= hold_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.busy      = !ready;
  assign bus.done      = done_q;
  assign bus.ack_n     = ack_q;
  assign bus.scl_o     = scl_q;
  assign bus.sda_o     = sda_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: a per-cycle waveform model built from quarter lists,
// two DUTs (QDIV=5 and QDIV=1) and directed command sequences.
module tb_i2c_byte_master;

  typedef struct packed {
    logic scl;
    logic sda;
    logic done;
    logic busy;
    logic ready;
    logic chk_ack;
    logic ack_v;
    logic ackwin;
  } ent_t;

  logic       clk_in;
  logic       rst_s   [2];
  logic       v_s     [2];
  logic [7:0] d_s     [2];
  logic       st_s    [2];
  logic       sp_s    [2];
  logic       ackv_s  [2];
  wire        scl_w   [2];
  wire        sda_w   [2];
  wire        done_w  [2];
  wire        ready_w [2];
  wire        busy_w  [2];
  wire        ack_w   [2];
  wire  [2:0] dbg_w   [2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int QD = (g == 0) ? 5 : 1;
    logic sda_m;

    i2c_byte_master_if bus ();

    assign bus.cmd_valid = v_s[g];
    assign bus.cmd_data  = d_s[g];
    assign bus.cmd_start = st_s[g];
    assign bus.cmd_stop  = sp_s[g];
    assign bus.sda_i     = sda_m;
    assign scl_w[g]      = bus.scl_o;
    assign sda_w[g]      = bus.sda_o;
    assign done_w[g]     = bus.done;
    assign ready_w[g]    = bus.cmd_ready;
    assign busy_w[g]     = bus.busy;
    assign ack_w[g]      = bus.ack_n;
    assign dbg_w[g]      = bus.dbg_state;

    i2c_byte_master #(.QDIV(QD)) dut (
      .clk_in (clk_in),
      .rst    (rst_s[g]),
      .bus    (bus)
    );

    // Model: on each accepted command expand the quarter list into one entry per cycle.
    initial begin : model
      ent_t       e;
      ent_t       exp_q[$];
      logic [2:0] qs[$];
      logic       hold_m;
      logic       exp_ack;
      logic       cur_ack;
      logic       b;
      hold_m  = 1'b0;
      exp_ack = 1'b1;
      cur_ack = 1'b1;
      sda_m   = 1'b1;
      forever begin
        @(negedge clk_in);
        if (rst_s[g] !== 1'b0) begin
          exp_q.delete();
          hold_m  = 1'b0;
          exp_ack = 1'b1;
          sda_m   = 1'b1;
        end else begin
          if (exp_q.size() > 0) e = exp_q.pop_front();
          else e = '{scl: !hold_m, sda: 1'b1, done: 1'b0, busy: 1'b0, ready: 1'b1,
                     chk_ack: 1'b1, ack_v: exp_ack, ackwin: 1'b0};
          sda_m = e.ackwin ? cur_ack : ~cur_ack;
          if (e.done) exp_ack = e.ack_v;
          chk("scl", 32'(scl_w[g]), 32'(e.scl));
          chk("sda", 32'(sda_w[g]), 32'(e.sda));
          chk("done", 32'(done_w[g]), 32'(e.done));
          chk("busy", 32'(busy_w[g]), 32'(e.busy));
          chk("cmd_ready", 32'(ready_w[g]), 32'(e.ready));
          if (e.chk_ack) chk("ack_n", 32'(ack_w[g]), 32'(e.ack_v));
          if (v_s[g] && e.ready) begin
            qs.delete();
            if (st_s[g] || !hold_m) begin
              qs.push_back({!hold_m, 1'b1, 1'b0});
              qs.push_back(3'b110);
              qs.push_back(3'b100);
              qs.push_back(3'b100);
            end
            for (int i = 7; i >= 0; i--) begin
              b = d_s[g][i];
              qs.push_back({1'b0, b, 1'b0});
              qs.push_back({1'b0, b, 1'b0});
              qs.push_back({1'b1, b, 1'b0});
              qs.push_back({1'b1, b, 1'b0});
            end
            qs.push_back(3'b010);
            qs.push_back(3'b010);
            qs.push_back(3'b111);
            qs.push_back(3'b110);
            if (sp_s[g]) begin
              qs.push_back(3'b000);
              qs.push_back(3'b100);
              qs.push_back(3'b110);
              qs.push_back(3'b110);
            end
            foreach (qs[j])
              repeat (QD) exp_q.push_back('{scl: qs[j][2], sda: qs[j][1], done: 1'b0,
                busy: 1'b1, ready: 1'b0, chk_ack: 1'b0, ack_v: 1'b0, ackwin: qs[j][0]});
            hold_m  = !sp_s[g];
            cur_ack = ackv_s[g];
            exp_q.push_back('{scl: !hold_m, sda: 1'b1, done: 1'b1, busy: 1'b0, ready: 1'b1,
                              chk_ack: 1'b1, ack_v: cur_ack, ackwin: 1'b0});
          end
        end
      end
    end
  end

  // Presents a command from posedge+1 and returns just after its accepting edge.
  task automatic send(input int k, input logic [7:0] d, input logic s, input logic p,
                      input logic a);
    int n;
    n = 0;
    ackv_s[k] = a;
    d_s[k]    = d;
    st_s[k]   = s;
    sp_s[k]   = p;
    v_s[k]    = 1'b1;
    while (!ready_w[k] && n < 1000) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    if (n >= 1000) chk("accept timeout", 32'(n), 32'd0);
    @(posedge clk_in);
    #1;
    v_s[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int start, output int cyc);
    cyc = start;
    do begin
      @(posedge clk_in);
      #1;
      cyc++;
    end while (!done_w[k] && cyc < 2000);
  endtask

  initial begin : main
    int cyc;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b0; v_s[k] = 1'b0; d_s[k] = 8'h00;
      st_s[k] = 1'b0; sp_s[k] = 1'b0; ackv_s[k] = 1'b0;
    end
    #1;
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst scl", 32'(scl_w[k]), 32'd1);
      chk("rst sda", 32'(sda_w[k]), 32'd1);
      chk("rst ready", 32'(ready_w[k]), 32'd1);
      chk("rst busy", 32'(busy_w[k]), 32'd0);
      chk("rst done", 32'(done_w[k]), 32'd0);
      chk("rst ack_n", 32'(ack_w[k]), 32'd1);
      chk("rst dbg_state", 32'(dbg_w[k]), 32'd0);
    end
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;

    // 0xA5 with ACK, then with NACK; STOP in both.
    send(0, 8'hA5, 1'b1, 1'b1, 1'b0);
    wait_done(0, 0, cyc);
    chk("t1 latency", 32'(cyc), 32'd220);
    chk("t1 ack_n", 32'(ack_w[0]), 32'd0);
    chk("t1 scl idle", 32'(scl_w[0]), 32'd1);
    chk("t1 sda idle", 32'(sda_w[0]), 32'd1);
    repeat (4) @(posedge clk_in);
    #1;
    send(0, 8'hA5, 1'b1, 1'b1, 1'b1);
    wait_done(0, 0, cyc);
    chk("t2 latency", 32'(cyc), 32'd220);
    chk("t2 ack_n", 32'(ack_w[0]), 32'd1);
    chk("t2 sda idle", 32'(sda_w[0]), 32'd1);

    // Back-to-back: second command presented in the done cycle.
    repeat (3) @(posedge clk_in);
    #1;
    send(0, 8'h3C, 1'b1, 1'b0, 1'b0);
    wait_done(0, 0, cyc);
    chk("t3 first latency", 32'(cyc), 32'd200);
    send(0, 8'hFF, 1'b0, 1'b1, 1'b1);
    wait_done(0, 0, cyc);
    chk("t3 second latency", 32'(cyc), 32'd200);
    chk("t3 ack_n", 32'(ack_w[0]), 32'd1);

    // Enter HOLD, linger, then issue a repeated START.
    repeat (2) @(posedge clk_in);
    #1;
    send(0, 8'h81, 1'b1, 1'b0, 1'b0);
    wait_done(0, 0, cyc);
    chk("t4 hold latency", 32'(cyc), 32'd200);
    repeat (7) @(posedge clk_in);
    #1;
    chk("t4 hold scl", 32'(scl_w[0]), 32'd0);
    chk("t4 hold sda", 32'(sda_w[0]), 32'd1);
    send(0, 8'hC3, 1'b1, 1'b0, 1'b1);
    chk("t4 rs q0 scl", 32'(scl_w[0]), 32'd0);
    chk("t4 rs q0 sda", 32'(sda_w[0]), 32'd1);
    repeat (5) @(posedge clk_in);
    #1;
    chk("t4 rs q1 scl", 32'(scl_w[0]), 32'd1);
    chk("t4 rs q1 sda", 32'(sda_w[0]), 32'd1);
    repeat (5) @(posedge clk_in);
    #1;
    chk("t4 rs q2 scl", 32'(scl_w[0]), 32'd1);
    chk("t4 rs q2 sda", 32'(sda_w[0]), 32'd0);
    wait_done(0, 10, cyc);
    chk("t4 rs latency", 32'(cyc), 32'd200);
    chk("t4 ack_n", 32'(ack_w[0]), 32'd1);

    // Reset in the middle of BIT 3 (BIT 3 spans cycles 80..99 after accept).
    send(0, 8'hA5, 1'b1, 1'b1, 1'b0);
    repeat (84) @(posedge clk_in);
    #1;
    rst_s[0] = 1'b1;
    #1;
    chk("t5 rst scl", 32'(scl_w[0]), 32'd1);
    chk("t5 rst sda", 32'(sda_w[0]), 32'd1);
    chk("t5 rst busy", 32'(busy_w[0]), 32'd0);
    chk("t5 rst ready", 32'(ready_w[0]), 32'd1);
    repeat (2) @(posedge clk_in);
    #1;
    rst_s[0] = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    send(0, 8'h5A, 1'b1, 1'b1, 1'b0);
    wait_done(0, 0, cyc);
    chk("t5 after rst latency", 32'(cyc), 32'd220);
    chk("t5 ack_n", 32'(ack_w[0]), 32'd0);

    // QDIV=1 with ignored cmd_valid pulses while busy.
    send(1, 8'h00, 1'b1, 1'b1, 1'b0);
    fork
      begin
        repeat (3) begin
          repeat (4) @(posedge clk_in);
          #1;
          d_s[1] = 8'($urandom_range(255));
          st_s[1] = 1'b0;
          sp_s[1] = 1'b0;
          v_s[1] = 1'b1;
          @(posedge clk_in);
          #1;
          v_s[1] = 1'b0;
        end
      end
      wait_done(1, 0, cyc);
    join
    chk("t6 latency", 32'(cyc), 32'd44);
    chk("t6 ack_n", 32'(ack_w[1]), 32'd0);
    chk("t6 scl idle", 32'(scl_w[1]), 32'd1);

    repeat (5) @(posedge clk_in);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
